// File: rtl/tbb_bus_writer.sv
// tbb_bus_writer
//   Host-side bus master for the TBB1143 sound core's 4-bit register port.
//   Register writes (4-bit address, 8-bit data) are accepted over a
//   valid/ready handshake, buffered in a small FIFO, and serialised as three
//   nibble transfers (address with A0=1, data[3:0], data[7:4]) on D/A0/WR
//   with programmable setup, strobe and hold times.
//
// Parameters
//   SETUP      cycles D/A0 are stable before WR rises (1..15)
//   WR_HIGH    cycles WR is held high (1..15)
//   HOLD       cycles D/A0 are held after WR falls (1..15)
//   FIFO_DEPTH buffered write requests (power of two, 2..16)
//
// Ports
//   CLK        clock for all logic
//   RST        synchronous, active-low reset
//   req_valid  write request present
//   req_ready  FIFO can accept a request (registered !full)
//   req_addr   target register address
//   req_data   register data
//   D          nibble bus to the sound core
//   A0         1 = address nibble, 0 = data nibble
//   WR         active-high write strobe; core latches D/A0 on its fall
//   busy       FIFO non-empty or a transfer in progress
module tbb_bus_writer #(
  parameter int unsigned SETUP      = 1,
  parameter int unsigned WR_HIGH    = 2,
  parameter int unsigned HOLD       = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic [3:0] D,
  output logic       A0,
  output logic       WR,
  output logic       busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  SETUP_LAST  = 4'(SETUP - 1);
  localparam logic [3:0]  STROBE_LAST = 4'(WR_HIGH - 1);
  localparam logic [3:0]  HOLD_LAST   = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   cur_q, cur_d;      // {addr, data} of the write in flight
  logic [3:0]    dbus_q, dbus_d;
  logic          a0_q, a0_d;
  logic          wr_q;
  logic          busy_q;
  logic          ready_q;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [11:0]   head;
  logic          push, pop;

  assign head = mem_q[rptr_q];
  // ready is the registered !full, so a full FIFO refuses a push even when
  // the FSM pops on the same edge.
  assign push = req_valid && ready_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 4'd1;
    idx_d   = idx_q;
    cur_d   = cur_q;
    dbus_d  = dbus_q;
    a0_d    = a0_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          cur_d   = head;
          idx_d   = '0;
          dbus_d  = head[11:8];
          a0_d    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (phase_q == STROBE_LAST) begin
          phase_d = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          phase_d = '0;
          if (idx_q != 2'd2) begin
            idx_d   = idx_q + 2'd1;
            dbus_d  = (idx_q == 2'd0) ? cur_q[3:0] : cur_q[7:4];
            a0_d    = 1'b0;
            state_d = S_SETUP;
          end else if (cnt_q != '0) begin
            // Chain straight into the next queued write, no IDLE cycle.
            pop     = 1'b1;
            cur_d   = head;
            idx_d   = '0;
            dbus_d  = head[11:8];
            a0_d    = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      dbus_q  <= '0;
      a0_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      dbus_q  <= dbus_d;
      a0_q    <= a0_d;
      // Outputs are registered from next-state values so they line up with
      // the state they describe.
      wr_q    <= (state_d == S_STROBE);
      busy_q  <= (state_d != S_IDLE) || (cnt_d != '0);
      ready_q <= (cnt_d != FULL_CNT);
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && push) begin
      mem_q[wptr_q] <= {req_addr, req_data};
    end
  end

  assign req_ready = ready_q;
  assign D         = dbus_q;
  assign A0        = a0_q;
  assign WR        = wr_q;
  assign busy      = busy_q;

endmodule

// File: doc/tbb_bus_writer.md
# tbb_bus_writer

Host-side bus master for the TBB1143 sound core's 4-bit register port. It accepts whole register writes (4-bit address, 8-bit data) over a valid/ready interface and buffers them in a small FIFO. It serialises each write into nibble transfers on the D[3:0]/A0/WR pins with programmable setup, strobe and hold times. It sits on the controller side of the board or test harness, driving the same pins that the sound core samples.

## Interface

- SETUP, default 1: cycles D/A0 are stable before WR rises; legal range 1..15.
- WR_HIGH, default 2: cycles WR is held high; legal range 1..15.
- HOLD, default 1: cycles D/A0 are held after WR falls; legal range 1..15.
- FIFO_DEPTH, default 4: number of buffered write requests; power of two, 2..16.
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous, active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  FIFO can accept a request.
- req_addr  in  4  target register address.
- req_data  in  8  register data.
- D  out  4  nibble bus to the sound core (D0..D3).
- A0  out  1  1 = address nibble, 0 = data nibble.
- WR  out  1  active-high write strobe; the core latches D/A0 on the falling edge.
- busy  out  1  FIFO non-empty or a transfer is in progress.

## Operation

- Handshake: a request is pushed on an edge where req_valid && req_ready. req_ready = !full. A push is refused when the FIFO is full, even if a pop occurs on the same edge.
- Each request becomes 3 nibble transfers, in this order:
  - addr with A0=1;
  - data[3:0] with A0=0;
  - data[7:4] with A0=0.
- FSM states: IDLE, SETUP, STROBE, HOLD. It uses a 2-bit nibble index (0..2) and a 4-bit phase counter.
- IDLE: if the FIFO is non-empty, pop the head, load D/A0 for nibble 0, and go to SETUP.
- SETUP: WR=0 for SETUP cycles, then go to STROBE.
- STROBE: WR=1 for WR_HIGH cycles, then go to HOLD.
- HOLD: WR=0 for HOLD cycles. D/A0 are unchanged. Then:
  - if the index is below 2, increment it, load the next nibble, and go to SETUP;
  - otherwise, if the FIFO is non-empty, pop the head, load nibble 0, and go to SETUP (back-to-back writes with no IDLE cycle);
  - otherwise go to IDLE.
- D and A0 change only on an edge that enters SETUP. They hold their value in IDLE.
- All outputs are registered.
- busy = (state != IDLE) || !empty.
- Reset (RST=0 on an edge):
  - state=IDLE, FIFO emptied, D=0, A0=0, WR=0, busy=0, req_ready=0 while RST=0;
  - req_ready=1 on the first edge after release;
  - reset mid-transfer drops WR on that edge, and in-flight and queued writes are discarded.

## Timing

- Push at edge k into an empty FIFO with the FSM in IDLE:
  - pop and D/A0 are valid after edge k+1;
  - WR rises after edge k+1+SETUP;
  - WR falls after edge k+1+SETUP+WR_HIGH.
- One nibble takes SETUP+WR_HIGH+HOLD cycles. One register write takes 3*(SETUP+WR_HIGH+HOLD) cycles; with defaults, 12 cycles.
- Back-to-back requests: the next request's address nibble enters SETUP on the edge that ends the previous HOLD, with no gap cycle.
- busy falls on the edge that enters IDLE after the final HOLD.
- Push and pop on the same edge with the FIFO neither empty nor full: the occupancy count is unchanged.
- The FIFO occupancy counter wraps correctly across read and write pointer wrap-around.

## Test plan

- Reset, defaults: RST=0 for 3 cycles, then 1 -> D=0, A0=0, WR=0, busy=0 during reset; req_ready=1 one cycle after release.
- Single write, addr=0x5, data=0xA3, defaults:
  - D/A0 sequence 5/1, 3/0, A/0;
  - WR high for exactly 2 cycles per nibble, 3 pulses in total;
  - busy low 12 cycles after the pop;
  - a core-model monitor latching on WR fall reads reg5=0xA3.
- Back-to-back: 4 pushes on consecutive cycles ({1,0x11}, {2,0x22}, {3,0x33}, {4,0x44}) ->
  - req_ready stays 1 because the first push is popped before the fourth arrives;
  - 12 WR pulses, no IDLE cycle between writes, 48 cycles from first pop to idle.
- FIFO full: hold req_valid high with FIFO_DEPTH=4 and the FSM stalled mid-transfer ->
  - req_ready=0 once 4 entries are queued;
  - refused data is not lost from the source's view;
  - ready rises on the edge after the next pop.
- Parameters SETUP=3, WR_HIGH=1, HOLD=2 -> WR high for 1 cycle, D stable 3 cycles before and 2 cycles after each pulse, 18 cycles per write.
- Mid-transfer reset: assert RST=0 during the STROBE of the second nibble with 2 requests queued -> WR=0 on that edge, busy=0, no further WR pulses after release.
